// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//  Shared constants, FSM state encoding and the byte-packing helper for the
//  instruction-memory loader.
//   SIZE_IM : default IM depth in 32-bit words (must match the IM instance)
//   WORD_W  : IM word width
//   BYTE_W  : stream byte width
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int SIZE_IM = 128;
    localparam int WORD_W  = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Append one byte below the lower three bytes of a word: the byte that
    // arrived first ends up in the most significant position after four calls.
    function automatic logic [WORD_W-1:0] pack_byte(
        input logic [WORD_W-BYTE_W-1:0] low,
        input logic [BYTE_W-1:0]        b
    );
        return {low, b};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//  Byte-stream handshake plus the IM write port driven by the loader.
//   byte_in / byte_valid : stream byte from the host side
//   byte_ready           : loader accepts the byte this cycle
//   we / waddr / wdata   : single-cycle IM write (byte address, word aligned)
//  modport master : the loader
//  modport slave  : host / IM side
// -----------------------------------------------------------------------------
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [WORD_W-1:0] waddr;
    logic [WORD_W-1:0] wdata;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output we,
        output waddr,
        output wdata
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  we,
        input  waddr,
        input  wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_loader_byte_packer
//  32-bit MSB-first shift register with a 2-bit byte counter.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear at the start of a load
//   shift_en   : a byte is transferred this cycle
//   byte_in    : byte to shift in
//   word       : current shift register contents
//   last_byte  : the next shifted byte completes a word (three already held)
// -----------------------------------------------------------------------------
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              last_byte
);

    logic [WORD_W-1:0] word_r;
    logic [1:0]        byte_cnt_r;

    // Shift register and byte counter; the counter wraps to 0 on the 4th byte.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_r     <= {WORD_W{1'b0}};
            byte_cnt_r <= 2'd0;
        end else if (shift_en) begin
            word_r     <= pack_byte(word_r[WORD_W-BYTE_W-1:0], byte_in);
            byte_cnt_r <= byte_cnt_r + 2'd1;
        end else begin
            word_r     <= word_r;
            byte_cnt_r <= byte_cnt_r;
        end
    end

    assign word      = word_r;
    assign last_byte = (byte_cnt_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//  Fills the 32-bit-word instruction memory from a byte stream before the CPU
//  is released. Bytes are packed MSB-first; each complete word is written to
//  the IM with a single-cycle write.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle pulse, honoured only while idle
//   len      : number of words to load, sampled with start
//   busy     : high from the cycle after an accepted start through the done cycle
//   done     : one-cycle pulse at the end of a load (normal or error)
//   err      : sticky, len exceeded SIZE_IM; cleared by the next accepted start
//   bus      : byte stream handshake and IM write port (master side)
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int SIZE_IM = imem_loader_pkg::SIZE_IM,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    imem_loader_if.master    bus
);

    localparam logic [CNT_W-1:0] SIZE_IM_C = CNT_W'(SIZE_IM);

    state_t            state_r;
    logic [CNT_W-1:0]  len_r;
    logic [CNT_W-1:0]  word_idx_r;
    logic              byte_ready_r;
    logic              we_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [WORD_W-1:0] waddr_r;
    logic [WORD_W-1:0] wdata_r;

    logic              xfer_s;
    logic              clr_s;
    logic [WORD_W-1:0] pk_word_s;
    logic              pk_last_s;
    logic [CNT_W-1:0]  word_idx_nxt_s;
    logic              unused_s;

    // byte_ready is only ever high in RECV, so a transfer implies RECV.
    assign xfer_s         = bus.byte_valid & byte_ready_r;
    assign clr_s          = (state_r == S_IDLE) & start;
    assign word_idx_nxt_s = word_idx_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // The top byte of the shift register is shifted out when the word is
    // completed, so only the lower three bytes feed the write data.
    assign unused_s = ^pk_word_s[WORD_W-1:WORD_W-BYTE_W];

    imem_loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_s),
        .shift_en  (xfer_s),
        .byte_in   (bus.byte_in),
        .word      (pk_word_s),
        .last_byte (pk_last_s)
    );

    // Load sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            len_r        <= {CNT_W{1'b0}};
            word_idx_r   <= {CNT_W{1'b0}};
            byte_ready_r <= 1'b0;
            we_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            waddr_r      <= {WORD_W{1'b0}};
            wdata_r      <= {WORD_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    byte_ready_r <= 1'b0;
                    we_r         <= 1'b0;
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    if (start) begin
                        len_r      <= len;
                        word_idx_r <= {CNT_W{1'b0}};
                        err_r      <= 1'b0;
                        busy_r     <= 1'b1;
                        if (len == {CNT_W{1'b0}}) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end else if (len > SIZE_IM_C) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end else begin
                            state_r      <= S_RECV;
                            byte_ready_r <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end

                S_RECV: begin
                    // The 4th byte is combined with the three already held so
                    // the write lands in the very next cycle.
                    if (xfer_s && pk_last_s) begin
                        state_r      <= S_WRITE;
                        byte_ready_r <= 1'b0;
                        we_r         <= 1'b1;
                        waddr_r      <= {{(WORD_W-CNT_W-2){1'b0}}, word_idx_r, 2'b00};
                        wdata_r      <= pack_byte(pk_word_s[WORD_W-BYTE_W-1:0], bus.byte_in);
                    end else begin
                        state_r <= S_RECV;
                    end
                end

                S_WRITE: begin
                    we_r       <= 1'b0;
                    word_idx_r <= word_idx_nxt_s;
                    if (word_idx_nxt_s == len_r) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r      <= S_RECV;
                        byte_ready_r <= 1'b1;
                    end
                end

                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end

                default: begin
                    state_r      <= S_IDLE;
                    byte_ready_r <= 1'b0;
                    we_r         <= 1'b0;
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_r;
    assign bus.we         = we_r;
    assign bus.waddr      = waddr_r;
    assign bus.wdata      = wdata_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int CNT_W = 8;
    localparam int DEPTH = 128;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             busy, done, err;

    imem_loader_if bus();

    imem_loader #(.SIZE_IM(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    // Bench-side instruction memory with an async read port
    logic [31:0] im [0:DEPTH-1];
    logic [31:0] im_raddr = 32'd0;
    logic [31:0] im_rdata;
    assign im_rdata = im[im_raddr[8:2]];

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  tx_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare -----------------
    logic        e_we = 1'b0, e_done = 1'b0, e_busy = 1'b0, e_err = 1'b0, e_ready = 1'b0;
    logic [31:0] e_addr = 32'd0, e_data = 32'd0;
    int          m_len = 0, m_words = 0;
    logic [7:0]  m_bytes[$];

    always @(negedge clk) begin : mon
        logic n_we, n_done, n_busy, n_err, n_ready;
        logic [31:0] n_addr, n_data;
        cyc++;
        if (chk_en) begin
            chk("we", bus.we, e_we);
            if (e_we && bus.we) begin
                chk("waddr", bus.waddr, e_addr);
                chk("wdata", bus.wdata, e_data);
            end
            chk("done", done, e_done);
            chk("busy", busy, e_busy);
            chk("err", err, e_err);
            chk("byte_ready", bus.byte_ready, e_ready);
            if (bus.we) begin
                im[bus.waddr[8:2]] = bus.wdata;
                wr_addr_q.push_back(bus.waddr);
                wr_data_q.push_back(bus.wdata);
            end
            if (done) done_cnt++;
        end
        n_we = 1'b0; n_done = 1'b0; n_busy = e_busy; n_err = e_err;
        n_ready = e_ready; n_addr = e_addr; n_data = e_data;
        if (e_done) n_busy = 1'b0;
        if (e_we) begin
            m_words++;
            if (m_words == m_len) begin n_done = 1'b1; n_ready = 1'b0; end
            else n_ready = 1'b1;
        end
        if (start && !e_busy) begin
            m_len = int'(len); m_words = 0; m_bytes.delete();
            n_busy = 1'b1; n_err = 1'b0;
            if (m_len == 0) n_done = 1'b1;
            else if (m_len > DEPTH) begin n_err = 1'b1; n_done = 1'b1; end
            else n_ready = 1'b1;
        end
        if (bus.byte_valid && e_ready) begin
            m_bytes.push_back(bus.byte_in);
            if (m_bytes.size() == 4) begin
                n_we = 1'b1; n_ready = 1'b0;
                n_addr = 32'(m_words) << 2;
                n_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_bytes.delete();
            end
        end
        if (rst) begin
            n_we = 1'b0; n_done = 1'b0; n_busy = 1'b0; n_err = 1'b0; n_ready = 1'b0;
            m_bytes.delete(); m_words = 0;
        end
        e_we = n_we; e_done = n_done; e_busy = n_busy; e_err = n_err;
        e_ready = n_ready; e_addr = n_addr; e_data = n_data;
    end

    // ---------------- stimulus helpers (all driven at posedge + 1) ----------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = CNT_W'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic send_all(input int gap, input int restart_idx);
        int k = 0;
        int budget = 0;
        bit restarted = 1'b0;
        bit acc;
        while (k < tx_q.size() && budget < 2000) begin
            bus.byte_valid = ($urandom_range(99) >= gap) ? 1'b1 : 1'b0;
            bus.byte_in    = bus.byte_valid ? tx_q[k] : 8'($urandom);
            if (k == restart_idx && !restarted) begin
                start = 1'b1; len = 8'd5; restarted = 1'b1;
            end else begin
                start = 1'b0;
            end
            acc = bus.byte_valid && bus.byte_ready;
            tick();
            budget++;
            if (acc) k++;
        end
        bus.byte_valid = 1'b0;
        start = 1'b0;
        chk("send_bound", (k == tx_q.size()) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk("idle_bound", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic rand_bytes(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    endtask

    function automatic logic [31:0] tx_word(input int w);
        return {tx_q[4*w], tx_q[4*w+1], tx_q[4*w+2], tx_q[4*w+3]};
    endfunction

    logic [31:0] ref_data[$];
    int          d0;

    initial begin
        rst = 1'b1; start = 1'b0; len = '0;
        bus.byte_valid = 1'b0; bus.byte_in = 8'd0;
        for (int i = 0; i < DEPTH; i++) im[i] = 32'd0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // 1. reset values, idle with start low
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", bus.byte_ready, 1'b0);
        repeat (20) tick();
        chk("idle_waddr", bus.waddr, 32'd0);
        chk("idle_wdata", bus.wdata, 32'd0);
        chk("idle_nwr", wr_addr_q.size(), 32'd0);

        // 2. two words back-to-back
        clear_log();
        tx_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        d0 = done_cnt;
        do_start(2);
        send_all(0, -1);
        wait_idle();
        chk("t2_nwr", wr_addr_q.size(), 32'd2);
        if (wr_addr_q.size() == 2) begin
            chk("t2_addr0", wr_addr_q[0], 32'h0);
            chk("t2_data0", wr_data_q[0], 32'h12345678);
            chk("t2_addr1", wr_addr_q[1], 32'h4);
            chk("t2_data1", wr_data_q[1], 32'h9ABCDEF0);
        end
        chk("t2_done_cnt", done_cnt - d0, 32'd1);

        // 3. len=3, no-gap reference then ~50% valid gaps with the same bytes
        rand_bytes(12);
        clear_log();
        do_start(3);
        send_all(0, -1);
        wait_idle();
        ref_data = wr_data_q;
        clear_log();
        do_start(3);
        send_all(50, -1);
        wait_idle();
        chk("t3_nwr", wr_addr_q.size(), 32'd3);
        if (wr_addr_q.size() == 3 && ref_data.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t3_addr", wr_addr_q[i], 32'(4 * i));
                chk("t3_vs_nogap", wr_data_q[i], ref_data[i]);
                chk("t3_vs_bytes", wr_data_q[i], tx_word(i));
            end
        end

        // 4. len=0 and len>SIZE_IM: no writes; err sticky, cleared by next start
        clear_log();
        do_start(0);
        chk("t4_done_len0", done, 1'b1);
        wait_idle();
        do_start(129);
        chk("t4_err", err, 1'b1);
        chk("t4_done_big", done, 1'b1);
        wait_idle();
        repeat (3) tick();
        chk("t4_err_sticky", err, 1'b1);
        chk("t4_nwr", wr_addr_q.size(), 32'd0);
        rand_bytes(4);
        do_start(1);
        chk("t4_err_clr", err, 1'b0);
        send_all(30, -1);
        wait_idle();
        chk("t4_len1_nwr", wr_addr_q.size(), 32'd1);

        // 5. reset after two bytes of the first word, then a clean one-word load
        clear_log();
        tx_q = '{8'hA1, 8'hB2};
        do_start(4);
        send_all(0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", busy, 1'b0);
        chk("t5_ready", bus.byte_ready, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_we", bus.we, 1'b0);
        chk("t5_wdata", bus.wdata, 32'd0);
        repeat (5) tick();
        chk("t5_nwr_after_rst", wr_addr_q.size(), 32'd0);
        tx_q = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        do_start(1);
        send_all(0, -1);
        wait_idle();
        chk("t5_nwr", wr_addr_q.size(), 32'd1);
        if (wr_addr_q.size() == 1) begin
            chk("t5_addr", wr_addr_q[0], 32'h0);
            chk("t5_data", wr_data_q[0], 32'hCAFEBABE);
        end

        // 6. start with len=5 mid-load is ignored; IM read-back of word 2
        rand_bytes(16);
        clear_log();
        d0 = done_cnt;
        do_start(4);
        send_all(20, 6);
        wait_idle();
        repeat (10) tick();
        chk("t6_nwr", wr_addr_q.size(), 32'd4);
        chk("t6_done_cnt", done_cnt - d0, 32'd1);
        im_raddr = 32'h8;
        #1;
        chk("t6_im_word2", im_rdata, tx_word(2));

        // random loads against the model
        for (int r = 0; r < 6; r++) begin
            int l;
            l = int'($urandom_range(1, 6));
            rand_bytes(4 * l);
            clear_log();
            do_start(l);
            send_all(int'($urandom_range(0, 60)), -1);
            wait_idle();
            chk("rnd_nwr", wr_addr_q.size(), 32'(l));
            if (wr_data_q.size() == l)
                for (int i = 0; i < l; i++) chk("rnd_data", wr_data_q[i], tx_word(i));
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
